// File: rtl/l2_pkg.sv
// Shared layer-2 constants used by the demux and its downstream FIFO instances.
// Depth and thresholds here are defaults; instances may override them.
package l2_pkg;

  localparam int L2_DATA_WIDTH      = 8;
  localparam int L2_ADDR_WIDTH      = 2;
  localparam int L2_ALMOST_FULL_TH  = 3;
  localparam int L2_ALMOST_EMPTY_TH = 1;

endpackage

// File: rtl/fifo_l2_mem.sv
// Dual-port register array for fifo_l2: synchronous write and a registered read.
// The read register resets to zero and holds its value when no read is requested.
module fifo_l2_mem
  import l2_pkg::*;
#(
  parameter int DATA_WIDTH = L2_DATA_WIDTH,
  parameter int ADDR_WIDTH = L2_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // A same-address write in this cycle is not visible yet: read-before-write.
  always_ff @(posedge clk) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_l2.sv
// 8-bit synchronous FIFO downstream of the layer-2 demux, pop/valid read handshake.
// FIFO_L2_ERR_EN adds sticky errOverflow/errUnderflow outputs.
module fifo_l2
  import l2_pkg::*;
#(
  parameter int DATA_WIDTH      = L2_DATA_WIDTH,
  parameter int ADDR_WIDTH      = L2_ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = L2_ALMOST_FULL_TH,
  parameter int ALMOST_EMPTY_TH = L2_ALMOST_EMPTY_TH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Entrada,
  input  logic                  validEntrada,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] Salida,
  output logic                  validSalida,
  output logic                  full,
  output logic                  empty,
  output logic                  almostFull,
  output logic                  almostEmpty
`ifdef FIFO_L2_ERR_EN
  ,
  output logic                  errOverflow,
  output logic                  errUnderflow
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] AF_TH = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  push_ok;
  logic                  pop_ok;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok     = pop & ~empty;
    push_ok    = validEntrada & (~full | pop_ok);
    count_next = count;
    if (push_ok && !pop_ok)      count_next = count + 1'b1;
    else if (!push_ok && pop_ok) count_next = count - 1'b1;
  end

  // Flags are registered from count_next so they track count with no lag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      validSalida <= 1'b0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almostFull  <= 1'b0;
      almostEmpty <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      validSalida <= pop_ok;
      full        <= (count_next == DEPTH);
      empty       <= (count_next == '0);
      almostFull  <= (count_next >= AF_TH);
      almostEmpty <= (count_next <= AE_TH);
    end
  end

  fifo_l2_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (Entrada),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (Salida)
  );

`ifdef FIFO_L2_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      errOverflow  <= 1'b0;
      errUnderflow <= 1'b0;
    end else begin
      if (validEntrada && full && !pop_ok) errOverflow  <= 1'b1;
      if (pop && empty)                    errUnderflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_l2.sv
// Directed and randomized bench for fifo_l2, checked against a queue-based model.
module tb_fifo_l2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Entrada;
  logic       validEntrada;
  logic       pop;
  logic [7:0] Salida;
  logic       validSalida;
  logic       full, empty, almostFull, almostEmpty;
`ifdef FIFO_L2_ERR_EN
  logic       errOverflow, errUnderflow;
`endif

  fifo_l2 dut (
    .clk          (clk),
    .reset        (reset),
    .Entrada      (Entrada),
    .validEntrada (validEntrada),
    .pop          (pop),
    .Salida       (Salida),
    .validSalida  (validSalida),
    .full         (full),
    .empty        (empty),
    .almostFull   (almostFull),
    .almostEmpty  (almostEmpty)
`ifdef FIFO_L2_ERR_EN
    ,
    .errOverflow  (errOverflow),
    .errUnderflow (errUnderflow)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;

  logic [7:0] q [$];
  logic [7:0] m_sal = 8'h00;
  logic       m_val = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ":Salida"}, Salida, m_sal);
    chk({ctx, ":validSalida"}, {7'd0, validSalida}, {7'd0, m_val});
    chk({ctx, ":full"}, {7'd0, full}, {7'd0, q.size() == 4});
    chk({ctx, ":empty"}, {7'd0, empty}, {7'd0, q.size() == 0});
    chk({ctx, ":almostFull"}, {7'd0, almostFull}, {7'd0, q.size() >= 3});
    chk({ctx, ":almostEmpty"}, {7'd0, almostEmpty}, {7'd0, q.size() <= 1});
`ifdef FIFO_L2_ERR_EN
    chk({ctx, ":errOverflow"}, {7'd0, errOverflow}, {7'd0, m_ovf});
    chk({ctx, ":errUnderflow"}, {7'd0, errUnderflow}, {7'd0, m_unf});
`endif
  endtask

  // One clock with reset released; the model applies the FIFO rules to its queue.
  task automatic step(input string ctx, input logic v, input logic p, input logic [7:0] d);
    logic pok;
    validEntrada = v;
    pop          = p;
    Entrada      = d;
    @(posedge clk);
    pok = p && (q.size() != 0);
    if (v && q.size() == 4 && !pok) m_ovf = 1'b1;
    if (p && q.size() == 0)         m_unf = 1'b1;
    if (pok) begin
      m_sal = q.pop_front();
      m_val = 1'b1;
    end else begin
      m_val = 1'b0;
    end
    if (v && q.size() < 4) q.push_back(d);
    #1;
    check_all(ctx);
  endtask

  task automatic do_reset(input int unsigned cycles);
    for (int unsigned i = 0; i < cycles; i++) begin
      reset        = 1'b0;
      validEntrada = 1'b1;
      pop          = 1'b1;
      Entrada      = 8'h77;
      @(posedge clk);
      q.delete();
      m_sal = 8'h00;
      m_val = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      #1;
      check_all("reset");
    end
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    Entrada      = 8'h00;
    validEntrada = 1'b0;
    pop          = 1'b0;
    #1;

    do_reset(2);

    // Fill and drain, with an overflow attempt while full.
    step("fill1", 1'b1, 1'b0, 8'hA1);
    step("fill2", 1'b1, 1'b0, 8'hA2);
    step("fill3", 1'b1, 1'b0, 8'hA3);
    step("fill4", 1'b1, 1'b0, 8'hA4);
    step("ovf",   1'b1, 1'b0, 8'hFF);
    step("idle",  1'b0, 1'b0, 8'h00);
    step("drain1", 1'b0, 1'b1, 8'h00);
    chk("drain1_A1", Salida, 8'hA1);
    step("drain2", 1'b0, 1'b1, 8'h00);
    step("drain3", 1'b0, 1'b1, 8'h00);
    step("drain4", 1'b0, 1'b1, 8'h00);
    chk("drain4_A4", Salida, 8'hA4);
    step("underflow", 1'b0, 1'b1, 8'h00);
    chk("hold_after_empty_pop", Salida, 8'hA4);

    // Simultaneous push and pop while full.
    do_reset(1);
    for (int unsigned i = 0; i < 4; i++) step("refill", 1'b1, 1'b0, 8'hB0 + 8'(i));
    step("full_pushpop", 1'b1, 1'b1, 8'h55);
    chk("full_pushpop_oldest", Salida, 8'hB0);
    for (int unsigned i = 0; i < 4; i++) step("full_drain", 1'b0, 1'b1, 8'h00);
    chk("last_is_55", Salida, 8'h55);

    // Simultaneous push and pop while empty: no fall-through.
    step("empty_pushpop", 1'b1, 1'b1, 8'h3C);
    step("pop_3c", 1'b0, 1'b1, 8'h00);
    chk("pop_3c_value", Salida, 8'h3C);

    // Streaming so both pointers wrap more than twice.
    for (int unsigned i = 0; i < 10; i++) step("wrap", 1'b1, i > 0, 8'h60 + 8'(i));
    step("wrap_tail", 1'b0, 1'b1, 8'h00);

    // Random traffic.
    for (int unsigned i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

    // Reset with two words stored discards them.
    do_reset(1);
    step("pre_rst1", 1'b1, 1'b0, 8'hC1);
    step("pre_rst2", 1'b1, 1'b0, 8'hC2);
    do_reset(1);
    step("post_rst_pop", 1'b0, 1'b1, 8'h00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_l2.md
Name: fifo_l2

Overview:
- 8-bit synchronous FIFO that sits directly downstream of the layer-2 demux.
- One instance per demux output: it buffers `Salida0`/`Salida1` traffic qualified by the matching `validSalida`.
- Presents data to the next-stage consumer under a pop/valid handshake.
- Exports full/empty and almost-full/almost-empty status so upstream flow control can pause the demux.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 2, log2 of depth; depth = 2**ADDR_WIDTH = 4 entries.
- ALMOST_FULL_TH, 3, `almostFull` asserted when count >= this value.
- ALMOST_EMPTY_TH, 1, `almostEmpty` asserted when count <= this value.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset.
- Entrada  input  DATA_WIDTH  write data from the demux output.
- validEntrada  input  1  push request; Entrada captured when accepted.
- pop  input  1  read request from the downstream consumer.
- Salida  output  DATA_WIDTH  registered read data.
- validSalida  output  1  Salida holds a newly popped word this cycle.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- almostFull  output  1  count >= ALMOST_FULL_TH.
- almostEmpty  output  1  count <= ALMOST_EMPTY_TH.

Behaviour:
- Reset (reset==0 at a clk edge):
  - wr_ptr = rd_ptr = count = 0.
  - Salida = 0, validSalida = 0, full = 0, empty = 1, almostFull = 0, almostEmpty = 1.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words; the first edge with reset==1 behaves as an empty FIFO.
- Push acceptance: push_ok = validEntrada & (!full | pop_ok).
  - When accepted, Entrada is written to mem[wr_ptr] and wr_ptr increments.
- Pop acceptance: pop_ok = pop & !empty.
  - When accepted, Salida <= mem[rd_ptr] and validSalida <= 1 at the same edge, so there is one-cycle read latency; rd_ptr increments.
  - Otherwise validSalida <= 0 and Salida holds its last value.
- Pointers are ADDR_WIDTH wide and wrap naturally from depth-1 to 0.
- count is ADDR_WIDTH+1 bits and updates as follows:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted push and pop.
- Full with push and pop in the same cycle: both are accepted and count stays at depth.
- Empty with push and pop in the same cycle: the pop is ignored (no fall-through), the push is accepted, count becomes 1, validSalida = 0.
- Push while full without pop: the word is dropped and no state changes.
- Pop while empty: ignored.
- Status flags are registered and derived from the next-state count, so they are valid in the same cycle as the count change with no extra latency.
- A write and a read to the same address in one cycle cannot occur except when full, where the read returns the old word (read-before-write).

Optional Feature:
- Macro: FIFO_L2_ERR_EN.
- When defined, adds the output port `errOverflow` (1 bit). It is set sticky on any cycle where validEntrada & full & !pop_ok, and cleared only by reset.
- Adds the output port `errUnderflow` (1 bit). It is set sticky on pop & empty.
- When not defined, these ports and their registers are absent; dropped pushes and empty pops are silently ignored as above.

Decomposition:
- Shared package `l2_pkg`:
  - L2_DATA_WIDTH = 8 constant.
  - Default depth/threshold constants reused by the demux and FIFO instances.
- One sub-module, `fifo_l2_mem`: a simple dual-port register array (DATA_WIDTH x 2**ADDR_WIDTH) with a synchronous write port and a registered read port, both on clk.
- Pointer, count and flag logic stays in fifo_l2.

Test Plan:
- Reset: hold reset=0 for 2 cycles with validEntrada=1 and pop=1.
  - Expect empty=1, full=0, validSalida=0, Salida=8'h00, almostEmpty=1 throughout.
- Fill and drain: push 8'hA1, 8'hA2, 8'hA3, 8'hA4 on consecutive cycles.
  - full=1 after the 4th edge; almostFull=1 after the 3rd.
  - Then pop 4 times: Salida = A1, A2, A3, A4 with validSalida=1 each cycle; empty=1 after the last pop.
- Overflow: with the FIFO full, push 8'hFF with pop=0.
  - Count remains 4; subsequent pops return A1..A4 only.
  - With FIFO_L2_ERR_EN defined, errOverflow=1 and stays 1 until reset.
- Simultaneous at full: full FIFO, assert validEntrada=1 (8'h55) and pop=1.
  - Salida = oldest word, full stays 1, and 8'h55 is the last word drained.
- Simultaneous at empty: empty FIFO, validEntrada=1 (8'h3C) and pop=1 in the same cycle.
  - validSalida=0, empty=0 next cycle.
  - A pop on the following cycle returns 8'h3C.
- Wrap-around and mid-operation reset:
  - Stream 10 words with interleaved push/pop so the pointers wrap at least twice; verify order preserved.
  - Then assert reset=0 while count=2; after release, empty=1 and a pop yields validSalida=0.
